// File: rtl/rr_pkg.sv
// rr_pkg: shared constants and grant-decode helpers for the round-robin request issuer
package rr_pkg;
    localparam int NUM_REQ = 4;
    localparam int SRC_W = 2;
    function automatic logic onehot(input logic [NUM_REQ-1:0] v);
        return (v != '0) && ((v & (v - NUM_REQ'(1))) == '0);
    endfunction
    function automatic logic [SRC_W-1:0] encode(input logic [NUM_REQ-1:0] v);
        logic [SRC_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) idx = SRC_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/rr_req_fifo.sv
// rr_req_fifo: per-channel request queue with registered occupancy count
module rr_req_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              full
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    always_comb begin
        do_push = push && !full;
        do_pop = pop && cnt_q != '0;
        cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
    assign full = cnt_q == CNT_W'(DEPTH);
    assign count = cnt_q;
    assign head_data = mem_q[rd_q];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop) rd_q <= rd_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= push_data;
endmodule

// File: rtl/rr_request_issuer.sv
// rr_request_issuer: queues four client channels, requests the arbiter and issues one beat per grant
module rr_request_issuer
    import rr_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        in_valid,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    output logic [NUM_REQ-1:0]        in_ready,
    output logic [NUM_REQ-1:0]        req_sigs,
    input  logic [NUM_REQ-1:0]        grant_sigs,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    output logic                      stale_grant,
    output logic                      grant_err
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic [CNT_W-1:0] cnt [NUM_REQ];
    logic [DATA_W-1:0] head [NUM_REQ];
    logic [NUM_REQ-1:0] full, pop;
    logic grant_oh, any_pop;
    logic [SRC_W-1:0] src_d;
    logic out_valid_q, stale_q, err_q;
    logic [DATA_W-1:0] out_data_q;
    logic [SRC_W-1:0] out_src_q;
    assign grant_oh = onehot(grant_sigs);
    assign src_d = encode(grant_sigs);
    assign any_pop = |pop;
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ch
        assign pop[i] = grant_sigs[i] && grant_oh && cnt[i] != '0;
        // last entry withdraws its request in the cycle it pops, hiding the arbiter's grant lag
        assign req_sigs[i] = (cnt[i] > CNT_W'(1)) || (cnt[i] == CNT_W'(1) && !pop[i]);
        assign in_ready[i] = !full[i];
        rr_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk(clk),
            .rst(rst),
            .push(in_valid[i] && in_ready[i]),
            .push_data(in_data[i*DATA_W +: DATA_W]),
            .pop(pop[i]),
            .head_data(head[i]),
            .count(cnt[i]),
            .full(full[i])
        );
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_src_q <= '0;
            stale_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            out_valid_q <= any_pop;
            if (any_pop) begin
                out_data_q <= head[src_d];
                out_src_q <= src_d;
            end
            stale_q <= grant_oh && !any_pop;
            err_q <= grant_sigs != '0 && !grant_oh;
        end
    end
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_src = out_src_q;
    assign stale_grant = stale_q;
    assign grant_err = err_q;
endmodule

// File: tb/tb_rr_request_issuer.sv
// tb_rr_request_issuer: directed-vector self-checking bench for rr_request_issuer
module tb_rr_request_issuer;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] in_valid, in_ready, req_sigs, grant_sigs;
    logic [31:0] in_data;
    logic out_valid, stale_grant, grant_err;
    logic [7:0] out_data;
    logic [1:0] out_src;
    int errs = 0;
    int checks = 0;
    int ptr;

    rr_request_issuer #(.DATA_W(8), .DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .req_sigs(req_sigs),
        .grant_sigs(grant_sigs),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_src(out_src),
        .stale_grant(stale_grant),
        .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [7:0] d);
        in_valid = 4'(1 << ch);
        in_data = 32'(d) << (8 * ch);
        tick();
        in_valid = '0;
    endtask

    task automatic beat(input string tag, input logic [1:0] src, input logic [7:0] d);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_src"}, 32'(out_src), 32'(src));
        chk({tag, "_data"}, 32'(out_data), 32'(d));
    endtask

    function automatic logic [3:0] rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return 4'(1 << ((p + k) % 4));
        return 4'b0000;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        grant_sigs = '0;
        #1;
        chk("rst_req", 32'(req_sigs), 0);
        chk("rst_ready", 32'(in_ready), 32'hf);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_src", 32'(out_src), 0);
        chk("rst_stale", 32'(stale_grant), 0);
        chk("rst_err", 32'(grant_err), 0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_req", 32'(req_sigs), 0);
            chk("idle_valid", 32'(out_valid), 0);
            chk("idle_ready", 32'(in_ready), 32'hf);
        end

        push(2, 8'hA1);
        chk("ch2_req_after_push", 32'(req_sigs), 32'b0100);
        push(2, 8'hA2);
        push(2, 8'hA3);
        grant_sigs = 4'b0100;
        #1 chk("ch2_req_c3", 32'(req_sigs), 32'b0100);
        tick();
        beat("ch2_b1", 2, 8'hA1);
        #1 chk("ch2_req_c2", 32'(req_sigs), 32'b0100);
        tick();
        beat("ch2_b2", 2, 8'hA2);
        #1 chk("ch2_req_last_pop", 32'(req_sigs), 0);
        tick();
        beat("ch2_b3", 2, 8'hA3);
        chk("ch2_req_empty", 32'(req_sigs), 0);
        grant_sigs = '0;
        tick();
        chk("ch2_idle_valid", 32'(out_valid), 0);
        chk("ch2_hold_data", 32'(out_data), 32'hA3);
        chk("ch2_hold_src", 32'(out_src), 2);

        in_valid = 4'b1111;
        in_data = 32'h40302010;
        tick();
        in_valid = '0;
        ptr = 0;
        for (int k = 0; k < 4; k++) begin
            grant_sigs = '0;
            #1 grant_sigs = rr_pick(req_sigs, ptr);
            tick();
            beat("all", 2'(k), 8'((k + 1) * 16));
            chk("all_stale", 32'(stale_grant), 0);
            ptr = k + 1;
        end
        grant_sigs = '0;
        tick();
        chk("all_drained_req", 32'(req_sigs), 0);

        push(1, 8'h51);
        push(1, 8'h52);
        push(1, 8'h53);
        chk("full_ready_c3", 32'(in_ready), 32'hf);
        push(1, 8'h54);
        chk("full_ready_c4", 32'(in_ready), 32'b1101);
        push(1, 8'h55);
        chk("full_ignored_ready", 32'(in_ready), 32'b1101);
        grant_sigs = 4'b0010;
        tick();
        beat("full_p1", 1, 8'h51);
        chk("full_ready_after_pop", 32'(in_ready), 32'hf);
        in_valid = 4'b0010;
        in_data = 32'h00005600;
        tick();
        in_valid = '0;
        beat("full_pushpop", 1, 8'h52);
        chk("full_ready_c3_again", 32'(in_ready), 32'hf);
        tick();
        beat("full_p3", 1, 8'h53);
        tick();
        beat("full_p4", 1, 8'h54);
        #1 chk("full_req_last", 32'(req_sigs), 0);
        tick();
        beat("full_p5", 1, 8'h56);
        grant_sigs = '0;
        tick();
        chk("full_idle_valid", 32'(out_valid), 0);
        chk("full_idle_req", 32'(req_sigs), 0);

        grant_sigs = 4'b0001;
        tick();
        chk("stale_pulse", 32'(stale_grant), 1);
        chk("stale_valid", 32'(out_valid), 0);
        grant_sigs = '0;
        tick();
        chk("stale_clear", 32'(stale_grant), 0);
        in_valid = 4'b0011;
        in_data = 32'h00008877;
        tick();
        in_valid = '0;
        grant_sigs = 4'b0011;
        tick();
        chk("err_pulse", 32'(grant_err), 1);
        chk("err_valid", 32'(out_valid), 0);
        chk("err_stale", 32'(stale_grant), 0);
        grant_sigs = '0;
        #1 chk("err_req_kept", 32'(req_sigs), 32'b0011);
        tick();
        chk("err_clear", 32'(grant_err), 0);
        grant_sigs = 4'b0001;
        tick();
        beat("err_ch0", 0, 8'h77);
        grant_sigs = 4'b0010;
        tick();
        beat("err_ch1", 1, 8'h88);
        grant_sigs = '0;
        tick();

        push(3, 8'h91);
        push(3, 8'h92);
        chk("mid_req", 32'(req_sigs), 32'b1000);
        grant_sigs = 4'b1000;
        tick();
        beat("mid_b1", 3, 8'h91);
        grant_sigs = '0;
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_req", 32'(req_sigs), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_ready", 32'(in_ready), 32'hf);
        tick();
        rst = 1'b0;
        #1 chk("mid_post_req", 32'(req_sigs), 0);
        grant_sigs = 4'b1000;
        tick();
        chk("mid_post_stale", 32'(stale_grant), 1);
        chk("mid_post_valid", 32'(out_valid), 0);
        grant_sigs = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_old_data", 32'(out_data), 0);
            chk("mid_no_valid", 32'(out_valid), 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/rr_request_issuer.md
Name: rr_request_issuer

Overview:
- Requester-side companion to the 4-way round-robin arbiter; one instance serves all four requesters.
- Queues transactions from four independent client channels and drives the arbiter's req_sigs.
- Consumes the arbiter's one-hot grant_sigs and issues exactly one beat per granted cycle onto a shared output bus, tagged with the source channel.

Parameters:
- NUM_REQ, 4, number of requester channels; fixed at 4 to match arbiter width; other values unsupported.
- DATA_W, 8, payload width per channel.
- DEPTH, 4, per-channel queue depth; power of two, at least 2.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  4  per-channel push strobe.
- in_data  input  4*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W].
- in_ready  output  4  per-channel space available.
- req_sigs  output  4  request vector to arbiter.
- grant_sigs  input  4  one-hot grant from arbiter; 0 means idle.
- out_valid  output  1  shared bus beat valid.
- out_data  output  DATA_W  shared bus payload.
- out_src  output  2  index of the channel that sourced the beat.
- stale_grant  output  1  one-cycle pulse: granted channel had an empty queue.
- grant_err  output  1  one-cycle pulse: grant_sigs is non-zero and not one-hot.

Behaviour:
- Reset (async, rst=1):
  - All queues emptied, pointers and counts set to 0.
  - out_valid=0, out_data=0, out_src=0, stale_grant=0, grant_err=0.
  - req_sigs=0 and in_ready=4'b1111 while rst is held.
- Reset mid-operation discards all queued data; no beat is emitted for it.
- Per-channel queue: a DEPTH-entry FIFO with count 0..DEPTH.
  - in_ready[i] = (count_i < DEPTH), computed from the registered count only; there is no pass-through when full.
  - Push occurs when in_valid[i] && in_ready[i]. Data pushed while full is ignored; asserting in_valid against full is a client protocol error.
- Pop condition: pop_i = grant_sigs[i] && onehot(grant_sigs) && count_i != 0.
- Simultaneous push and pop on the same channel: count unchanged, both take effect. The FIFO is first-in first-out, and pointers wrap modulo DEPTH.
- req_sigs[i] is combinational: (count_i > 1) || (count_i == 1 && !pop_i).
  - The last entry drops its request in the same cycle it pops, so the one-cycle grant lag of the arbiter never re-grants an empty channel.
  - A push into an empty queue raises req_sigs[i] in the following cycle, once the count is 1.
- Output register, updated every clock edge; latency is 1 cycle from grant to bus.
  - If a pop occurs: out_valid<=1, out_data<=head of the granted queue, out_src<=encode(grant_sigs).
  - Otherwise: out_valid<=0; out_data and out_src hold their last values.
- No backpressure on the output bus: the consumer must accept every beat.
- grant_sigs=0: no pop, no flags.
- One-hot grant to a channel with count=0: no pop, out_valid<=0, stale_grant<=1 for one cycle.
- Non-one-hot, non-zero grant: no pop on any channel, out_valid<=0, grant_err<=1 for one cycle.
- Fairness and rotation are owned by the arbiter. This block never masks requests and holds each request until its queue drains.

Decomposition:
- Shared package rr_pkg:
  - NUM_REQ and SRC_W=2.
  - onehot check function.
  - one-hot to index encode function.
- Sub-module rr_req_fifo (DATA_W, DEPTH):
  - Ports: clk, rst, push, push_data, pop, head_data, count, full.
  - Instantiated four times via generate.
- Top level holds the request logic, grant decode, output register and flags.

Test Plan:
- Reset then idle: rst pulse, no pushes -> req_sigs=0000, out_valid=0, in_ready=1111 throughout.
- Single channel drain: push 3 beats (0xA1,0xA2,0xA3) on ch2; drive grant=0100 each cycle req_sigs[2]=1 -> out_valid beats A1,A2,A3 with out_src=2, one cycle after each grant; req_sigs[2] falls in the cycle the third pop occurs.
- All channels loaded, arbiter model in loop: one beat each on ch0..ch3 (0x10,0x20,0x30,0x40) -> output order src 0,1,2,3 with matching data, no stale_grant.
- Full boundary: push DEPTH=4 beats on ch1 -> in_ready[1]=0; 5th in_valid ignored; one pop -> in_ready[1]=1 next cycle; simultaneous push+pop at count=3 keeps count=3.
- Stale and bad grants: grant=0001 with ch0 empty -> stale_grant pulse, out_valid=0; grant=0011 -> grant_err pulse, no queue count changes.
- Reset mid-operation: ch3 holds 2 entries, assert rst mid-cycle -> req_sigs and out_valid drop immediately; after release count=0 and no old data ever appears on out_data.
